id_exe_pipe_reg: RTL

//  Parametrised ID->EXE pipeline register with built-in hazard detection for the ARM-subset core.

---
 rtl/id_exe_pipe_reg.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/id_exe_pipe_reg.sv
// ID->EXE pipeline register with RAW/load-use hazard detection, bubble insertion
// on stall or flush, and a saturating count of stall cycles.
module id_exe_pipe_reg #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RADDR_W = 4,
  parameter int unsigned CMD_W   = 4,
  parameter int unsigned SHIFT_W = 12,
  parameter int unsigned IMM24_W = 24,
  parameter int unsigned FWD_EN  = 0,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [DATA_W-1:0]  id_pc,
  input  logic               id_wb_en,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               id_s,
  input  logic               id_b,
  input  logic [CMD_W-1:0]   id_exe_cmd,
  input  logic [DATA_W-1:0]  id_val_rn,
  input  logic [DATA_W-1:0]  id_val_rm,
  input  logic               id_imm,
  input  logic [SHIFT_W-1:0] id_shift_op,
  input  logic [IMM24_W-1:0] id_imm24,
  input  logic [RADDR_W-1:0] id_dest,
  input  logic [RADDR_W-1:0] id_src1,
  input  logic [RADDR_W-1:0] id_src2,
  input  logic               id_use_src1,
  input  logic               id_two_src,
  input  logic               mem_wb_en,
  input  logic [RADDR_W-1:0] mem_dest,
  input  logic               flush,
  output logic               stall,
  output logic               ex_valid,
  output logic               ex_wb_en,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_s,
  output logic               ex_b,
  output logic [CMD_W-1:0]   ex_exe_cmd,
  output logic [DATA_W-1:0]  ex_pc,
  output logic [DATA_W-1:0]  ex_val_rn,
  output logic [DATA_W-1:0]  ex_val_rm,
  output logic               ex_imm,
  output logic [SHIFT_W-1:0] ex_shift_op,
  output logic [IMM24_W-1:0] ex_imm24,
  output logic [RADDR_W-1:0] ex_dest,
  output logic [RADDR_W-1:0] ex_src1,
  output logic [RADDR_W-1:0] ex_src2,
  output logic [CNT_W-1:0]   stall_cnt
);

  typedef struct packed {
    logic valid;
    logic wb_en;
    logic mem_read;
    logic mem_write;
    logic s;
    logic b;
  } ctrl_t;

  typedef struct packed {
    logic [CMD_W-1:0]   exe_cmd;
    logic [DATA_W-1:0]  pc;
    logic [DATA_W-1:0]  val_rn;
    logic [DATA_W-1:0]  val_rm;
    logic               imm;
    logic [SHIFT_W-1:0] shift_op;
    logic [IMM24_W-1:0] imm24;
    logic [RADDR_W-1:0] dest;
    logic [RADDR_W-1:0] src1;
    logic [RADDR_W-1:0] src2;
  } data_t;

  ctrl_t            ctrl_q, ctrl_d;
  data_t            data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit_e1, hit_e2, hit_m1, hit_m2, haz;

  always_comb begin
    hit_e1 = ctrl_q.valid & ctrl_q.wb_en & (data_q.dest == id_src1);
    hit_e2 = ctrl_q.valid & ctrl_q.wb_en & (data_q.dest == id_src2);
    hit_m1 = mem_wb_en & (mem_dest == id_src1);
    hit_m2 = mem_wb_en & (mem_dest == id_src2);
    if (FWD_EN != 0) begin
      haz = id_valid & ctrl_q.mem_read &
            ((id_use_src1 & hit_e1) | (id_two_src & hit_e2));
    end else begin
      haz = id_valid & ((id_use_src1 & (hit_e1 | hit_m1)) |
                        (id_two_src  & (hit_e2 | hit_m2)));
    end
    stall = haz & ~flush & rst;
  end

  // Bubbles clear only the control bits; data fields keep their last value.
  always_comb begin
    ctrl_d = ctrl_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    if (flush) begin
      ctrl_d = '0;
    end else if (haz) begin
      ctrl_d = '0;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end else begin
      ctrl_d.valid     = id_valid;
      ctrl_d.wb_en     = id_valid & id_wb_en;
      ctrl_d.mem_read  = id_valid & id_mem_read;
      ctrl_d.mem_write = id_valid & id_mem_write;
      ctrl_d.s         = id_valid & id_s;
      ctrl_d.b         = id_valid & id_b;
      data_d.exe_cmd   = id_exe_cmd;
      data_d.pc        = id_pc;
      data_d.val_rn    = id_val_rn;
      data_d.val_rm    = id_val_rm;
      data_d.imm       = id_imm;
      data_d.shift_op  = id_shift_op;
      data_d.imm24     = id_imm24;
      data_d.dest      = id_dest;
      data_d.src1      = id_src1;
      data_d.src2      = id_src2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl_q <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign ex_valid     = ctrl_q.valid;
  assign ex_wb_en     = ctrl_q.wb_en;
  assign ex_mem_read  = ctrl_q.mem_read;
  assign ex_mem_write = ctrl_q.mem_write;
  assign ex_s         = ctrl_q.s;
  assign ex_b         = ctrl_q.b;
  assign ex_exe_cmd   = data_q.exe_cmd;
  assign ex_pc        = data_q.pc;
  assign ex_val_rn    = data_q.val_rn;
  assign ex_val_rm    = data_q.val_rm;
  assign ex_imm       = data_q.imm;
  assign ex_shift_op  = data_q.shift_op;
  assign ex_imm24     = data_q.imm24;
  assign ex_dest      = data_q.dest;
  assign ex_src1      = data_q.src1;
  assign ex_src2      = data_q.src2;
  assign stall_cnt    = cnt_q;

endmodule
